host_rx_arbiter: RTL and testbench
==================================

// Module: host_rx_arbiter
// PURPOSE
// - Packet-granular round-robin arbiter that shares the single host-side 9-bit packet bus between two packet sources.
//   - Source 0: the host receive path.
//   - Source 1: a locally generated packet source, e.g. the PTP/NMAC generator.
// - Reads whole packets out of two show-ahead FIFOs and emits them on ov_data/o_data_wr/ov_ctrl_data.
// - Sits between the source FIFOs and the packet distinguish / switching stage.
// - Never interleaves packets. Truncates oversize packets. Discards misaligned words.
// PARAMETERS
// - MAX_PKT_WORDS  1536  max words per packet incl. head and tail; longer packets are truncated
// - CNT_W          16    width of per-port packet counters
// PORTS
// - i_clk            in   1   system clock; all logic on rising edge
// - i_rst            in   1   asynchronous, active-high reset
// - i_arb_en         in   1   1 = new grants allowed (driven from cfg-finish); sampled only in IDLE
// - iv_data0         in   9   port0 FIFO show-ahead word; [8]=head/tail flag, [7:0]=byte
// - iv_ctrl_data0    in   19  port0 metadata, valid while the head word is on iv_data0
// - i_data_empty0    in   1   port0 FIFO empty
// - o_data_rd0       out  1   port0 FIFO pop
// - iv_data1, iv_ctrl_data1, i_data_empty1, o_data_rd1  as port0
// - ov_data          out  9   granted word, registered
// - o_data_wr        out  1   ov_data valid
// - ov_ctrl_data     out  19  metadata latched at head word, held until next head
// - ov_pkt_cnt0/1    out  CNT_W  packets forwarded per port, wrap at 2^CNT_W
// - o_trunc_pulse    out  1   one-cycle pulse on truncation
// - o_align_err_pulse out 1   one-cycle pulse per discarded misaligned word
// - ov_arb_state     out  2   current state, debug
// BEHAVIOUR
// Framing
// - A packet is a head word ([8]=1), zero or more body words ([8]=0), then a tail word ([8]=1).
// - Minimum packet length is 2 words.
// - A FIFO word is visible on iv_dataX while !i_data_emptyX. o_data_rdX pops it.
// Reset
// - All outputs are 0 and the state is IDLE.
// - last_grant=1, so port0 wins first. Word counter is 0.
// - Reset asserted mid-packet aborts immediately. No tail is emitted.
// States
// - IDLE (0): a port is eligible if !empty and the visible word has [8]=1.
//   - If i_arb_en=1, grant round-robin: the port other than last_grant wins a tie; otherwise the single eligible port.
//   - Register grant and go to XFER.
//   - A non-empty port whose visible word has [8]=0 is popped with no output and pulses o_align_err_pulse, whatever i_arb_en is.
//     If both ports are misaligned, both are popped in the same cycle.
// - XFER (1): o_data_rdG = !i_data_emptyG. Each pop registers the word to ov_data with o_data_wr=1 the next cycle.
//   - First pop is the head: latch iv_ctrl_dataG into ov_ctrl_data; counter=1.
//   - Each later pop increments the counter.
//   - Empty mid-packet: no pop, no output, stay in XFER with no timeout.
//   - Pop with [8]=1 and counter>1 is the tail: ov_pkt_cntG++, last_grant=G, go to IDLE.
//   - Pop number MAX_PKT_WORDS that is not a tail: output it with [8] forced to 1, pulse o_trunc_pulse, go to DROP.
// - DROP (2): o_data_rdG = !i_data_emptyG with no output. Pop with [8]=1 ends the packet; go to IDLE. ov_pkt_cntG is unchanged.
// Timing
// - Latency: FIFO non-empty at cycle t (IDLE) -> grant at t+1 -> first o_data_wr at t+2.
// - Tail popped at k -> IDLE at k+1 -> next head pop no earlier than k+2.
//   The output therefore has at least one idle cycle between packets.
// - o_data_rd0 and o_data_rd1 are both high in one cycle only for simultaneous misalignment discards in IDLE.
// - i_arb_en falling during XFER or DROP does not interrupt the packet. It blocks only the next grant.
// - A stray tail left at a FIFO head looks like a head and is forwarded as a packet start.
//   Upstream must guarantee framing.
// TESTING
// - T1: port0 words 1_AA,0_01,0_02,1_FF with ctrl 19'h12345, empty drops at t
//   -> o_data_wr at t+2..t+5; ov_data matches the words; ov_ctrl_data=19'h12345 from t+2; ov_pkt_cnt0=1.
// - T2: after reset, both ports hold two 4-word packets
//   -> output order p0,p1,p0,p1; >=1 idle cycle between packets; no overlapping rd.
// - T3: port1 goes empty for 5 cycles after its 2nd word
//   -> 5-cycle gap in o_data_wr; packet intact; ov_arb_state=1 throughout.
// - T4: MAX_PKT_WORDS=8, 12-word packet on port0
//   -> 8 writes, the 8th with ov_data[8]=1; o_trunc_pulse 1 cycle; 4 pops without wr; ov_pkt_cnt0 unchanged.
// - T5: port1 head word 0_55 at IDLE -> popped, o_align_err_pulse=1 for 1 cycle, no o_data_wr.
// - T6: i_arb_en=0 while port0 is mid-packet
//   -> packet completes; pending port1 packet not granted until i_arb_en=1.
//   i_rst during a later packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/host_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : host_rx_arbiter
// Description : Packet-granular round-robin arbiter. Two show-ahead FIFOs
//               (port0 = host receive path, port1 = local packet generator)
//               share one 9-bit host packet bus. Whole packets only; packets
//               longer than MAX_PKT_WORDS are truncated (last forwarded word
//               gets its head/tail flag forced) and the remainder is dropped.
//               Body words seen at a FIFO head while idle are discarded.
// Ports       : i_clk / i_rst          clock, async active-high reset
//               i_arb_en               allows new grants (sampled in IDLE)
//               iv_dataN/iv_ctrl_dataN FIFO word ([8]=head/tail) + metadata
//               i_data_emptyN          FIFO empty
//               o_data_rdN             FIFO pop
//               ov_data/o_data_wr      registered output word + valid
//               ov_ctrl_data           metadata latched from the head word
//               ov_pkt_cnt0/1          forwarded-packet counters (wrapping)
//               o_trunc_pulse          one cycle per truncated packet
//               o_align_err_pulse      one cycle per misaligned discard
//               ov_arb_state           current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module host_rx_arbiter #(
    parameter int MAX_PKT_WORDS = 1536,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arb_en,
    input  logic [8:0]       iv_data0,
    input  logic [18:0]      iv_ctrl_data0,
    input  logic             i_data_empty0,
    output logic             o_data_rd0,
    input  logic [8:0]       iv_data1,
    input  logic [18:0]      iv_ctrl_data1,
    input  logic             i_data_empty1,
    output logic             o_data_rd1,
    output logic [8:0]       ov_data,
    output logic             o_data_wr,
    output logic [18:0]      ov_ctrl_data,
    output logic [CNT_W-1:0] ov_pkt_cnt0,
    output logic [CNT_W-1:0] ov_pkt_cnt1,
    output logic             o_trunc_pulse,
    output logic             o_align_err_pulse,
    output logic [1:0]       ov_arb_state
);

    localparam int                c_wc_w      = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [c_wc_w-1:0] c_max_words = c_wc_w'(MAX_PKT_WORDS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_xfer = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    logic [1:0]        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [c_wc_w-1:0] r_wcnt;
    logic [8:0]        r_data;
    logic              r_wr;
    logic [18:0]       r_ctrl;
    logic [CNT_W-1:0]  r_pkt_cnt0;
    logic [CNT_W-1:0]  r_pkt_cnt1;
    logic              r_trunc;
    logic              r_align;

    logic [1:0]        w_state_nxt;
    logic              w_grant_nxt;
    logic              w_rd0;
    logic              w_rd1;
    logic              w_pop;
    logic              w_eli0;
    logic              w_eli1;
    logic              w_mis0;
    logic              w_mis1;
    logic [8:0]        w_g_data;
    logic [18:0]       w_g_ctrl;
    logic              w_g_empty;
    logic [c_wc_w-1:0] w_wcnt_inc;
    logic              w_is_tail;
    logic              w_at_max;

    // A visible flagged word at a FIFO head is a packet start; an unflagged
    // one cannot start a packet and is thrown away while idle.
    assign w_eli0 = !i_data_empty0 &&  iv_data0[8];
    assign w_eli1 = !i_data_empty1 &&  iv_data1[8];
    assign w_mis0 = !i_data_empty0 && !iv_data0[8];
    assign w_mis1 = !i_data_empty1 && !iv_data1[8];

    assign w_g_data  = r_grant ? iv_data1      : iv_data0;
    assign w_g_ctrl  = r_grant ? iv_ctrl_data1 : iv_ctrl_data0;
    assign w_g_empty = r_grant ? i_data_empty1 : i_data_empty0;

    // r_wcnt holds the number of words already popped for this packet, so a
    // flagged word is a tail only once the head has gone (r_wcnt != 0).
    assign w_wcnt_inc = r_wcnt + c_wc_w'(1);
    assign w_is_tail  = w_g_data[8] && (r_wcnt != '0);
    assign w_at_max   = (w_wcnt_inc == c_max_words);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rd0       = 1'b0;
        w_rd1       = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_rd0 = w_mis0;
                w_rd1 = w_mis1;
                if (i_arb_en && (w_eli0 || w_eli1)) begin
                    w_state_nxt = c_st_xfer;
                    // On a tie the port that did not send last time wins.
                    w_grant_nxt = (w_eli0 && w_eli1) ? ~r_last_grant : w_eli1;
                end
            end
            c_st_xfer: begin
                w_pop = !w_g_empty;
                w_rd0 = w_pop && !r_grant;
                w_rd1 = w_pop &&  r_grant;
                if (w_pop) begin
                    if (w_is_tail) begin
                        w_state_nxt = c_st_idle;
                    end else if (w_at_max) begin
                        w_state_nxt = c_st_drop;
                    end
                end
            end
            c_st_drop: begin
                w_pop = !w_g_empty;
                w_rd0 = w_pop && !r_grant;
                w_rd1 = w_pop &&  r_grant;
                if (w_pop && w_g_data[8]) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= c_st_idle;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wcnt       <= '0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_ctrl       <= '0;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
            r_trunc      <= 1'b0;
            r_align      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_wr    <= 1'b0;
            r_trunc <= 1'b0;
            r_align <= (r_state == c_st_idle) && (w_mis0 || w_mis1);
            if ((r_state == c_st_idle) && (w_state_nxt == c_st_xfer)) begin
                r_wcnt <= '0;
            end
            if ((r_state == c_st_xfer) && w_pop) begin
                r_wr   <= 1'b1;
                r_data <= w_g_data;
                r_wcnt <= w_wcnt_inc;
                if (r_wcnt == '0) begin
                    r_ctrl <= w_g_ctrl;
                end
                if (w_is_tail) begin
                    r_last_grant <= r_grant;
                    if (r_grant) begin
                        r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
                    end else begin
                        r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
                    end
                end else if (w_at_max) begin
                    // Close the truncated packet so downstream sees a tail.
                    r_data  <= {1'b1, w_g_data[7:0]};
                    r_trunc <= 1'b1;
                end
            end
        end
    end

    // Pops are combinational, so they are masked while reset is held to keep
    // every output quiet during reset.
    assign o_data_rd0        = w_rd0 && !i_rst;
    assign o_data_rd1        = w_rd1 && !i_rst;
    assign ov_data           = r_data;
    assign o_data_wr         = r_wr;
    assign ov_ctrl_data      = r_ctrl;
    assign ov_pkt_cnt0       = r_pkt_cnt0;
    assign ov_pkt_cnt1       = r_pkt_cnt1;
    assign o_trunc_pulse     = r_trunc;
    assign o_align_err_pulse = r_align;
    assign ov_arb_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_host_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_rx_arbiter
// Description : Self-checking bench for host_rx_arbiter. Source FIFOs are
//               modelled as queues; expected output words are generated per
//               packet from the framing/truncation rules and compared on
//               every valid output cycle, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_rx_arbiter;

    localparam int c_max   = 8;
    localparam int c_cnt_w = 16;

    typedef struct packed {
        logic [8:0]  d;
        logic [18:0] c;
        logic        first;
        logic        last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               arb_en = 1'b1;
    logic [8:0]         data0, data1;
    logic [18:0]        ctrl0, ctrl1;
    logic               empty0, empty1;
    logic               rd0, rd1;
    logic [8:0]         odata;
    logic               owr;
    logic [18:0]        octrl;
    logic [c_cnt_w-1:0] cnt0, cnt1;
    logic               trunc, align;
    logic [1:0]         st;

    logic [27:0] q0[$];
    logic [27:0] q1[$];
    exp_t        exp_q[$];
    int          exp_cnt[2];
    int          exp_trunc, exp_align;
    int          obs_trunc, obs_align, obs_pop0, obs_wr;
    int          passed = 0;
    int          total  = 0;
    logic        prev_last;

    host_rx_arbiter #(.MAX_PKT_WORDS(c_max), .CNT_W(c_cnt_w)) dut (
        .i_clk(clk), .i_rst(rst), .i_arb_en(arb_en),
        .iv_data0(data0), .iv_ctrl_data0(ctrl0), .i_data_empty0(empty0), .o_data_rd0(rd0),
        .iv_data1(data1), .iv_ctrl_data1(ctrl1), .i_data_empty1(empty1), .o_data_rd1(rd1),
        .ov_data(odata), .o_data_wr(owr), .ov_ctrl_data(octrl),
        .ov_pkt_cnt0(cnt0), .ov_pkt_cnt1(cnt1),
        .o_trunc_pulse(trunc), .o_align_err_pulse(align), .ov_arb_state(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
        else passed++;
    endtask

    task automatic refresh();
        logic [27:0] e;
        empty0 = (q0.size() == 0);
        e = empty0 ? 28'h0 : q0[0];
        data0 = e[8:0];
        ctrl0 = e[27:9];
        empty1 = (q1.size() == 0);
        e = empty1 ? 28'h0 : q1[0];
        data1 = e[8:0];
        ctrl1 = e[27:9];
    endtask

    task automatic push_word(input int port, input logic [8:0] w, input logic [18:0] c);
        if (port == 0) q0.push_back({c, w});
        else           q1.push_back({c, w});
        refresh();
    endtask

    task automatic push_pkt(input int port, input int n, input logic [7:0] base, input logic [18:0] c);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            push_word(port, {(i == 0 || i == n - 1), b}, c);
        end
    endtask

    // Output seen for one packet: first min(n, max) words, flag forced on the
    // last forwarded word when truncated; only complete packets are counted.
    task automatic expect_pkt(input int port, input int n, input logic [7:0] base, input logic [18:0] c);
        int m;
        m = (n > c_max) ? c_max : n;
        for (int i = 0; i < m; i++) begin
            exp_t       e;
            logic [7:0] b;
            b = base + 8'(i);
            e.d = {(i == 0 || i == n - 1), b};
            if (n > c_max && i == m - 1) e.d[8] = 1'b1;
            e.c = c;
            e.first = (i == 0);
            e.last = (i == m - 1);
            exp_q.push_back(e);
        end
        if (n > c_max) exp_trunc++;
        else exp_cnt[port]++;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        exp_q.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_trunc = 0;
        exp_align = 0;
        obs_trunc = 0;
        obs_align = 0;
        obs_pop0 = 0;
        obs_wr = 0;
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || st != 2'd0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        if (n >= budget) begin
            total++;
            $display("FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
        end
    endtask

    task automatic end_checks();
        chk("pkt_cnt0", 32'(cnt0), 32'(exp_cnt[0]));
        chk("pkt_cnt1", 32'(cnt1), 32'(exp_cnt[1]));
        chk("trunc_pulses", 32'(obs_trunc), 32'(exp_trunc));
        chk("align_pulses", 32'(obs_align), 32'(exp_align));
    endtask

    // Source FIFOs: a pop requested in a cycle takes effect after its edge.
    initial begin
        logic s0, s1;
        forever begin
            @(negedge clk);
            s0 = rd0;
            s1 = rd1;
            @(posedge clk);
            #1;
            if (s0 && q0.size() > 0) void'(q0.pop_front());
            if (s1 && q1.size() > 0) void'(q1.pop_front());
            refresh();
        end
    end

    // Output compare against the expected word stream.
    initial begin
        exp_t e;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_last = 1'b0;
            end else begin
                if (prev_last) chk("idle_gap", 32'(owr), 32'd0);
                prev_last = 1'b0;
                if (owr) begin
                    obs_wr++;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_wr: got data %0h required no write", odata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(odata), 32'(e.d));
                        if (e.first) chk("out_ctrl", 32'(octrl), 32'(e.c));
                        prev_last = e.last;
                    end
                end
                if (trunc) obs_trunc++;
                if (align) obs_align++;
                if (rd0) obs_pop0++;
                if (rd0 && rd1) chk("dual_rd", {28'h0, st, data0[8], data1[8]}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", 32'(owr), 32'd0);
        chk("rst_data", 32'(odata), 32'd0);
        chk("rst_ctrl", 32'(octrl), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_pulses", {30'h0, trunc, align}, 32'd0);
        chk("rst_state", 32'(st), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // T1: single port0 packet, literal timing and values
        @(posedge clk);
        #2;
        push_word(0, 9'h1AA, 19'h12345);
        push_word(0, 9'h001, 19'h12345);
        push_word(0, 9'h002, 19'h12345);
        push_word(0, 9'h1FF, 19'h12345);
        expect_pkt(0, 4, 8'hAA, 19'h12345);
        exp_q.delete();
        exp_q.push_back({9'h1AA, 19'h12345, 1'b1, 1'b0});
        exp_q.push_back({9'h001, 19'h12345, 1'b0, 1'b0});
        exp_q.push_back({9'h002, 19'h12345, 1'b0, 1'b0});
        exp_q.push_back({9'h1FF, 19'h12345, 1'b0, 1'b1});
        @(negedge clk);
        chk("t1_t_state", 32'(st), 32'd0);
        chk("t1_t_rd0", 32'(rd0), 32'd0);
        @(negedge clk);
        chk("t1_grant_state", 32'(st), 32'd1);
        chk("t1_grant_wr", 32'(owr), 32'd0);
        @(negedge clk);
        chk("t1_w0", {22'h0, owr, odata}, 32'h3AA);
        chk("t1_ctrl", 32'(octrl), 32'h12345);
        @(negedge clk);
        chk("t1_w1", {22'h0, owr, odata}, 32'h201);
        @(negedge clk);
        chk("t1_w2", {22'h0, owr, odata}, 32'h202);
        @(negedge clk);
        chk("t1_w3", {22'h0, owr, odata}, 32'h3FF);
        chk("t1_idle", 32'(st), 32'd0);
        chk("t1_ctrl_hold", 32'(octrl), 32'h12345);
        @(negedge clk);
        chk("t1_after_wr", 32'(owr), 32'd0);
        chk("t1_cnt0", 32'(cnt0), 32'd1);
        wait_drain(50);
        end_checks();

        // T2: round robin p0,p1,p0,p1
        do_reset();
        push_pkt(0, 4, 8'h10, 19'h0010A);
        push_pkt(0, 4, 8'h20, 19'h0020A);
        push_pkt(1, 4, 8'h30, 19'h0030B);
        push_pkt(1, 4, 8'h40, 19'h0040B);
        expect_pkt(0, 4, 8'h10, 19'h0010A);
        expect_pkt(1, 4, 8'h30, 19'h0030B);
        expect_pkt(0, 4, 8'h20, 19'h0020A);
        expect_pkt(1, 4, 8'h40, 19'h0040B);
        wait_drain(100);
        end_checks();
        chk("t2_cnt0", 32'(cnt0), 32'd2);
        chk("t2_cnt1", 32'(cnt1), 32'd2);

        // T3: port1 starves for 5 cycles mid-packet
        do_reset();
        push_word(1, 9'h160, 19'h0ABCD);
        push_word(1, 9'h061, 19'h0ABCD);
        expect_pkt(1, 4, 8'h60, 19'h0ABCD);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_gap_wr", 32'(owr), 32'd0);
            chk("t3_gap_state", 32'(st), 32'd1);
            @(posedge clk);
            #2;
            if (i == 3) begin
                push_word(1, 9'h062, 19'h0ABCD);
                push_word(1, 9'h163, 19'h0ABCD);
            end
        end
        @(negedge clk);
        chk("t3_resume", {22'h0, owr, odata}, 32'h262);
        wait_drain(50);
        end_checks();

        // T4: 12-word packet with 8-word limit
        do_reset();
        push_pkt(0, 12, 8'h70, 19'h7FFFF);
        expect_pkt(0, 12, 8'h70, 19'h7FFFF);
        wait_drain(100);
        end_checks();
        chk("t4_writes", 32'(obs_wr), 32'd8);
        chk("t4_pops", 32'(obs_pop0), 32'd12);
        chk("t4_cnt0", 32'(cnt0), 32'd0);
        chk("t4_trunc", 32'(obs_trunc), 32'd1);

        // T5: misaligned words are discarded
        do_reset();
        push_word(1, 9'h055, 19'h0);
        exp_align++;
        @(negedge clk);
        chk("t5_rd", {30'h0, rd0, rd1}, 32'd1);
        @(negedge clk);
        chk("t5_pulse", {30'h0, align, owr}, 32'd2);
        @(negedge clk);
        chk("t5_pulse_end", 32'(align), 32'd0);
        @(posedge clk);
        #2;
        push_word(0, 9'h001, 19'h0);
        push_word(1, 9'h002, 19'h0);
        exp_align++;   // both words go in the same cycle: one pulse cycle
        @(negedge clk);
        chk("t5_dual_rd", {30'h0, rd0, rd1}, 32'd3);
        wait_drain(50);
        end_checks();
        chk("t5_no_wr", 32'(obs_wr), 32'd0);

        // T6: i_arb_en dropped mid-packet, then reset mid-packet
        do_reset();
        push_pkt(0, 4, 8'h80, 19'h00080);
        expect_pkt(0, 4, 8'h80, 19'h00080);
        for (int n = 0; n < 20 && !owr; n++) @(negedge clk);
        chk("t6_started", 32'(owr), 32'd1);
        @(posedge clk);
        #2;
        arb_en = 1'b0;
        push_pkt(1, 4, 8'h90, 19'h00090);
        expect_pkt(1, 4, 8'h90, 19'h00090);
        repeat (12) @(posedge clk);
        #2;
        chk("t6_p1_held", q1.size(), 32'd4);
        chk("t6_state", 32'(st), 32'd0);
        chk("t6_cnt0", 32'(cnt0), 32'd1);
        chk("t6_cnt1", 32'(cnt1), 32'd0);
        arb_en = 1'b1;
        wait_drain(50);
        end_checks();
        chk("t6_cnt1_done", 32'(cnt1), 32'd1);
        push_pkt(0, 6, 8'hA0, 19'h000A0);
        expect_pkt(0, 6, 8'hA0, 19'h000A0);
        repeat (4) @(posedge clk);
        #2;
        chk("t6_mid_wr", 32'(owr), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_wr", 32'(owr), 32'd0);
        chk("t6_rst_data", 32'(odata), 32'd0);
        chk("t6_rst_ctrl", 32'(octrl), 32'd0);
        chk("t6_rst_cnt", {cnt0, cnt1}, 32'd0);
        chk("t6_rst_misc", {26'h0, trunc, align, st, rd0, rd1}, 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
